// File: rtl/adaptive_fir_core.sv
// Sequential transversal filter: y = sum(w[i]*x[i]) with one MAC per cycle, then error = d - y for the LMS block.
// Latency: a sample accepted at edge k gives out_valid after edge k+TAPS+1. The core accepts at most one sample per TAPS+3 cycles.
// Backpressure: in_ready is high only in IDLE. The result holds in OUT until out_ready, and new weights load on that handshake.
module adaptive_fir_core #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 15,
  parameter int TAPS  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0]        in_sample,
  input  logic [WIDTH-1:0]        in_desired,
  input  logic                    adapt_en,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_y,
  output logic [WIDTH-1:0]        out_error,
  output logic                    out_ovr,
  output logic                    weight_ovr,
  output logic [TAPS*WIDTH-1:0]   lms_din,
  output logic [WIDTH-1:0]        lms_error,
  output logic [TAPS*WIDTH-1:0]   lms_curr_weights,
  output logic                    lms_i_ovr,
  input  logic [TAPS*WIDTH-1:0]   lms_next_weights,
  input  logic [TAPS-1:0]         lms_next_weights_ovr
);

  localparam int IDX_W = (TAPS > 1) ? $clog2(TAPS) : 1;
  // Headroom of clog2(TAPS)+1 bits means the sum of TAPS full products never wraps
  localparam int ACC_W = 2*WIDTH + $clog2(TAPS) + 1;
  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_ERR  = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [TAPS*WIDTH-1:0]    x_q, x_d;
  logic [TAPS*WIDTH-1:0]    w_q, w_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0]         d_q, d_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [WIDTH-1:0]         y_q, y_d;
  logic [WIDTH-1:0]         err_q, err_d;
  logic                     ovr_q, ovr_d;
  logic                     wovr_q, wovr_d;

  logic signed [WIDTH-1:0]   x_sel, w_sel;
  logic signed [2*WIDTH-1:0] prod;
  logic signed [ACC_W-1:0]   acc_shr;
  logic                      y_sat, e_sat;
  logic [WIDTH-1:0]          y_val, e_val;
  logic [WIDTH:0]            e_full;

  // Pick the tap addressed by the MAC index and form its full-width product
  always_comb begin
    x_sel = '0;
    w_sel = '0;
    for (int i = 0; i < TAPS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        x_sel = x_q[i*WIDTH +: WIDTH];
        w_sel = w_q[i*WIDTH +: WIDTH];
      end
    end
    prod = w_sel * x_sel;
  end

  // Rescale the accumulator to WIDTH bits and form the saturated error
  always_comb begin
    acc_shr = acc_q >>> FRAC;
    // In range only when every bit from the sign down to bit WIDTH-1 agrees
    y_sat   = !((&acc_shr[ACC_W-1:WIDTH-1]) || !(|acc_shr[ACC_W-1:WIDTH-1]));
    y_val   = y_sat ? (acc_shr[ACC_W-1] ? SAT_MIN : SAT_MAX) : acc_shr[WIDTH-1:0];
    e_full  = {d_q[WIDTH-1], d_q} - {y_val[WIDTH-1], y_val};
    e_sat   = e_full[WIDTH] ^ e_full[WIDTH-1];
    e_val   = e_sat ? (e_full[WIDTH] ? SAT_MIN : SAT_MAX) : e_full[WIDTH-1:0];
  end

  // Next-state and datapath updates; everything holds unless its state acts on it
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    w_d     = w_q;
    acc_d   = acc_q;
    d_d     = d_q;
    idx_d   = idx_q;
    y_d     = y_q;
    err_d   = err_q;
    ovr_d   = ovr_q;
    wovr_d  = wovr_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          for (int i = 1; i < TAPS; i++) begin
            x_d[i*WIDTH +: WIDTH] = x_q[(i-1)*WIDTH +: WIDTH];
          end
          x_d[WIDTH-1:0] = in_sample;
          d_d            = in_desired;
          acc_d          = '0;
          idx_d          = '0;
          state_d        = S_MAC;
        end
      end
      S_MAC: begin
        acc_d = acc_q + {{(ACC_W-2*WIDTH){prod[2*WIDTH-1]}}, prod};
        if (idx_q == IDX_W'(TAPS-1)) begin
          state_d = S_ERR;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_ERR: begin
        y_d     = y_val;
        err_d   = e_val;
        ovr_d   = y_sat | e_sat;
        state_d = S_OUT;
      end
      S_OUT: begin
        if (out_ready) begin
          if (adapt_en) begin
            w_d    = lms_next_weights;
            wovr_d = wovr_q | (|lms_next_weights_ovr);
          end
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight sample and the weights
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      w_q     <= '0;
      acc_q   <= '0;
      d_q     <= '0;
      idx_q   <= '0;
      y_q     <= '0;
      err_q   <= '0;
      ovr_q   <= 1'b0;
      wovr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      w_q     <= w_d;
      acc_q   <= acc_d;
      d_q     <= d_d;
      idx_q   <= idx_d;
      y_q     <= y_d;
      err_q   <= err_d;
      ovr_q   <= ovr_d;
      wovr_q  <= wovr_d;
    end
  end

  assign in_ready         = (state_q == S_IDLE);
  assign out_valid        = (state_q == S_OUT);
  assign out_y            = y_q;
  assign out_error        = err_q;
  assign out_ovr          = ovr_q;
  assign weight_ovr       = wovr_q;
  assign lms_din          = x_q;
  assign lms_error        = err_q;
  assign lms_curr_weights = w_q;
  assign lms_i_ovr        = ovr_q;

endmodule

// File: tb/tb_adaptive_fir_core.sv
// Randomized bench for adaptive_fir_core: plays the LMS block, checks against an arithmetic filter model.
// Latency: measures accept-to-out_valid and requires TAPS+1 edges.
// Backpressure: holds out_ready low for random spans and requires stable outputs.
module tb_adaptive_fir_core;

  localparam int W = 16;
  localparam int T = 2;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_sample;
  logic [W-1:0]     in_desired;
  logic             adapt_en;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_y;
  logic [W-1:0]     out_error;
  logic             out_ovr;
  logic             weight_ovr;
  logic [T*W-1:0]   lms_din;
  logic [W-1:0]     lms_error;
  logic [T*W-1:0]   lms_curr_weights;
  logic             lms_i_ovr;
  logic [T*W-1:0]   lms_next_weights;
  logic [T-1:0]     lms_next_weights_ovr;

  int vectors;
  int miscompares;

  // Reference model state: plain signed integers per tap
  int mx [T];
  int mw [T];
  bit m_wovr;

  adaptive_fir_core #(.WIDTH(W), .FRAC(15), .TAPS(T)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .in_valid             (in_valid),
    .in_ready             (in_ready),
    .in_sample            (in_sample),
    .in_desired           (in_desired),
    .adapt_en             (adapt_en),
    .out_valid            (out_valid),
    .out_ready            (out_ready),
    .out_y                (out_y),
    .out_error            (out_error),
    .out_ovr              (out_ovr),
    .weight_ovr           (weight_ovr),
    .lms_din              (lms_din),
    .lms_error            (lms_error),
    .lms_curr_weights     (lms_curr_weights),
    .lms_i_ovr            (lms_i_ovr),
    .lms_next_weights     (lms_next_weights),
    .lms_next_weights_ovr (lms_next_weights_ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running, required done");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", tag, got, exp);
    end
  endtask

  function automatic logic [T*W-1:0] pack_x();
    logic [T*W-1:0] v;
    for (int i = 0; i < T; i++) v[i*W +: W] = 16'(mx[i]);
    return v;
  endfunction

  function automatic logic [T*W-1:0] pack_w();
    logic [T*W-1:0] v;
    for (int i = 0; i < T; i++) v[i*W +: W] = 16'(mw[i]);
    return v;
  endfunction

  function automatic longint clamp(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Filter output and error from the model's delay line and weights
  task automatic model_eval(input logic [W-1:0] d, output logic [W-1:0] ey,
                            output logic [W-1:0] ee, output logic eo);
    longint acc, ys, yc, es, ec;
    acc = 0;
    for (int i = 0; i < T; i++) acc += longint'(mw[i]) * longint'(mx[i]);
    ys = acc >>> 15;
    yc = clamp(ys);
    es = longint'($signed(d)) - yc;
    ec = clamp(es);
    ey = 16'(yc);
    ee = 16'(ec);
    eo = (ys != yc) || (es != ec);
  endtask

  task automatic model_reset();
    for (int i = 0; i < T; i++) begin
      mx[i] = 0;
      mw[i] = 0;
    end
    m_wovr = 1'b0;
  endtask

  // One full sample: accept, wait for result, optional backpressure, handshake
  task automatic send(input logic [W-1:0] xs, input logic [W-1:0] ds, input bit ad,
                      input logic [T*W-1:0] nw, input logic [T-1:0] nov,
                      input int hold, input bit keep_valid, output logic [W-1:0] got_y);
    int cnt;
    logic [W-1:0] ey, ee;
    logic eo;
    chk("in_ready_idle", {63'd0, in_ready}, 64'd1);
    in_valid   = 1'b1;
    in_sample  = xs;
    in_desired = ds;
    @(posedge clk); #1;
    if (!keep_valid) in_valid = 1'b0;
    in_sample = 16'($urandom);
    for (int i = T-1; i >= 1; i--) mx[i] = mx[i-1];
    mx[0] = int'($signed(xs));
    lms_next_weights = T*W'($urandom);
    chk("in_ready_busy", {63'd0, in_ready}, 64'd0);
    cnt = 0;
    while (out_valid !== 1'b1 && cnt < 40) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk("latency", 64'(cnt), 64'(T+1));
    model_eval(ds, ey, ee, eo);
    got_y = out_y;
    chk("out_y", 64'(out_y), 64'(ey));
    chk("out_error", 64'(out_error), 64'(ee));
    chk("lms_error", 64'(lms_error), 64'(ee));
    chk("out_ovr", {63'd0, out_ovr}, {63'd0, eo});
    chk("lms_i_ovr", {63'd0, lms_i_ovr}, {63'd0, eo});
    chk("lms_din", 64'(lms_din), 64'(pack_x()));
    chk("weights_pre", 64'(lms_curr_weights), 64'(pack_w()));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("bp_valid", {63'd0, out_valid}, 64'd1);
      chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
      chk("bp_y", 64'(out_y), 64'(ey));
      chk("bp_err", 64'(out_error), 64'(ee));
      chk("bp_din", 64'(lms_din), 64'(pack_x()));
      chk("bp_weights", 64'(lms_curr_weights), 64'(pack_w()));
    end
    in_valid             = 1'b0;
    adapt_en             = ad;
    lms_next_weights     = nw;
    lms_next_weights_ovr = nov;
    out_ready            = 1'b1;
    @(posedge clk); #1;
    out_ready            = 1'b0;
    adapt_en             = 1'($urandom_range(0, 1));
    lms_next_weights_ovr = 2'($urandom);
    if (ad) begin
      for (int i = 0; i < T; i++) mw[i] = int'($signed(nw[i*W +: W]));
      m_wovr = m_wovr | (|nov);
    end
    chk("post_valid", {63'd0, out_valid}, 64'd0);
    chk("post_in_ready", {63'd0, in_ready}, 64'd1);
    chk("post_weights", 64'(lms_curr_weights), 64'(pack_w()));
    chk("weight_ovr", {63'd0, weight_ovr}, {63'd0, m_wovr});
    chk("post_din", 64'(lms_din), 64'(pack_x()));
  endtask

  initial begin
    logic [W-1:0] gy;
    vectors              = 0;
    miscompares          = 0;
    rst                  = 1'b1;
    in_valid             = 1'b0;
    in_sample            = '0;
    in_desired           = '0;
    adapt_en             = 1'b0;
    out_ready            = 1'b0;
    lms_next_weights     = '0;
    lms_next_weights_ovr = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_y", 64'(out_y), 64'd0);
    chk("rst_out_error", 64'(out_error), 64'd0);
    chk("rst_out_ovr", {63'd0, out_ovr}, 64'd0);
    chk("rst_weight_ovr", {63'd0, weight_ovr}, 64'd0);
    chk("rst_din", 64'(lms_din), 64'd0);
    chk("rst_weights", 64'(lms_curr_weights), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Zero weights, then load {0x4000, 0x4000}
    send(16'h4000, 16'h2000, 1'b1, {16'h4000, 16'h4000}, 2'b00, 0, 1'b0, gy);
    chk("t1_y", 64'(gy), 64'h0000);
    send(16'h2000, 16'h0000, 1'b0, '0, 2'b00, 0, 1'b0, gy);
    chk("t2_first_y", 64'(gy), 64'h3000);
    send(16'h2000, 16'h0000, 1'b1, {16'h7FFF, 16'h7FFF}, 2'b00, 0, 1'b0, gy);
    chk("t2_second_y", 64'(gy), 64'h2000);

    // Saturation on both y and error
    send(16'h7FFF, 16'h8000, 1'b0, '0, 2'b00, 0, 1'b0, gy);
    send(16'h7FFF, 16'h8000, 1'b0, '0, 2'b00, 0, 1'b0, gy);
    chk("sat_y", 64'(gy), 64'h7FFF);
    chk("sat_err", 64'(out_error), 64'h8000);
    chk("sat_ovr", {63'd0, out_ovr}, 64'd1);

    // Backpressure with in_valid held high throughout
    send(16'h1111, 16'h0100, 1'b0, {16'h1234, 16'h1234}, 2'b11, 10, 1'b1, gy);

    // Adaptation gating and sticky overflow
    send(16'h0200, 16'h0300, 1'b0, {16'h1234, 16'h1234}, 2'b01, 1, 1'b0, gy);
    send(16'h0200, 16'h0300, 1'b1, {16'h1234, 16'h1234}, 2'b01, 0, 1'b0, gy);
    chk("gate_wovr_set", {63'd0, weight_ovr}, 64'd1);
    send(16'h0300, 16'h0300, 1'b1, {16'h1234, 16'h1234}, 2'b00, 0, 1'b0, gy);
    chk("gate_wovr_sticky", {63'd0, weight_ovr}, 64'd1);

    // Reset during MAC
    in_valid  = 1'b1;
    in_sample = 16'h5555;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("mrst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("mrst_weights", 64'(lms_curr_weights), 64'd0);
    chk("mrst_din", 64'(lms_din), 64'd0);
    chk("mrst_wovr", {63'd0, weight_ovr}, 64'd0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    send(16'h6000, 16'h0123, 1'b0, '0, 2'b00, 0, 1'b0, gy);
    chk("mrst_next_y", 64'(gy), 64'h0000);

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      send(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), T*W'($urandom),
           2'($urandom_range(0, 3)), $urandom_range(0, 3), 1'($urandom_range(0, 1)), gy);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
